serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared 1-bit full adder walks the
// operands LSB first, then holds the result until the consumer acknowledges.
//
// Handshake: a request is taken on a rising edge with start=1 and ready=1; a
// result is consumed on a rising edge with result_valid=1 and result_ack=1.
// Exactly one of ready/busy/result_valid is high in every cycle.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;

    // B is stored already inverted for subtraction; the +1 enters via the carry.
    full_adder u_fa (
        .a_i  (a_q[cnt_q]),
        .b_i  (b_q[cnt_q]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[cnt_q] = fa_s;
                carry_d      = fa_co;
                if (cnt_q == LAST_BIT) begin
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready        = (state_q == S_IDLE);
    assign busy         = (state_q == S_RUN);
    assign result_valid = (state_q == S_DONE);
    assign sum          = sum_q;
    assign cout         = cout_q;
    assign ovf          = ovf_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl (WIDTH=4) against an
// arithmetic reference model, with a scoreboard of expected {sum,cout,ovf}.

module tb_serial_add_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         result_valid;
    logic         result_ack;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sub          (sub),
        .a            (a),
        .b            (b),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .sum          (sum),
        .cout         (cout),
        .ovf          (ovf),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic msub);
        logic [W:0]   t;
        logic [W-1:0] s;
        logic         v;
        t = {1'b0, ma} + {1'b0, (msub ? ~mb : mb)} + (W+1)'(msub);
        s = t[W-1:0];
        if (msub)
            v = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
        else
            v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
        return {s, t[W], v};
    endfunction

    always @(negedge clk) begin
        if (mon_en)
            check("onehot", $countones({ready, busy, result_valid}), 1);
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
        int n = 0;
        while (!ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", ready, 1);
        a = ia;
        b = ib;
        sub = isub;
        start = 1'b1;
        exp_q.push_back(model(ia, ib, isub));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input bit noise);
        int cycles = 1;
        int busy_cnt = 0;
        logic [W+1:0] e;
        while (!result_valid && cycles < 64) begin
            if (busy) busy_cnt++;
            if (noise) begin
                start = 1'b1;
                a = W'($urandom_range(0, (1 << W) - 1));
                b = W'($urandom_range(0, (1 << W) - 1));
                sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("latency", cycles, W + 1);
        check("busy_cycles", busy_cnt, W);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_exp = e;
            check("result", {sum, cout, ovf}, e);
        end
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check("ack_ready", ready, 1);
        check("retain", {sum, cout, ovf}, last_exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        result_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_outs", {sum, cout, ovf}, 0);
        check("rst_state", dbg_state, 0);

        // Reference cases, first accept on the first edge after reset release
        issue(4'd3, 4'd5, 1'b0);
        wait_result(1'b0);
        check("add_3_5", {sum, cout, ovf}, {4'b1000, 1'b0, 1'b1});
        ack_result();
        issue(4'd15, 4'd1, 1'b0);
        wait_result(1'b0);
        check("add_15_1", {sum, cout, ovf}, {4'b0000, 1'b1, 1'b0});
        ack_result();
        issue(4'd5, 4'd7, 1'b1);
        wait_result(1'b0);
        check("sub_5_7", {sum, cout, ovf}, {4'b1110, 1'b0, 1'b0});
        ack_result();
        issue(4'd8, 4'd1, 1'b1);
        wait_result(1'b0);
        check("sub_8_1", {sum, cout, ovf}, {4'b0111, 1'b1, 1'b1});
        ack_result();

        // Random operands and modes
        for (int i = 0; i < 10; i++) begin
            issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            wait_result(1'b0);
            ack_result();
        end

        // start and operand churn during RUN must not disturb the operation
        issue(4'd7, 4'd9, 1'b0);
        wait_result(1'b1);
        ack_result();

        // Result held in DONE without ack
        issue(4'd12, 4'd6, 1'b1);
        wait_result(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", {result_valid, sum, cout, ovf}, {1'b1, last_exp});
        end
        ack_result();

        // Reset on the second RUN edge aborts the operation
        issue(4'd6, 4'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort_ready", ready, 1);
        check("abort_valid", result_valid, 0);
        check("abort_outs", {sum, cout, ovf}, 0);
        issue(4'd2, 4'd2, 1'b1);
        wait_result(1'b0);
        ack_result();

        // start together with ack in DONE is not accepted
        issue(4'd9, 4'd4, 1'b0);
        wait_result(1'b0);
        start = 1'b1;
        result_ack = 1'b1;
        a = 4'd1;
        b = 4'd14;
        sub = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check("same_edge_ready", ready, 1);
        check("same_edge_busy", busy, 0);
        check("same_edge_retain", {sum, cout, ovf}, last_exp);
        exp_q.push_back(model(4'd1, 4'd14, 1'b1));
        @(negedge clk);
        start = 1'b0;
        check("reaccept_busy", busy, 1);
        wait_result(1'b0);
        ack_result();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
